// File: rtl/mcu_mem_bus.sv
// Data-side bus controller: req/ack handshake with programmable wait states in front of
// an uninitialised data RAM, read/write output registers, synchronised input channels and
// an error response for unmapped addresses. One transfer is in flight at a time.
module mcu_mem_bus #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_DEPTH   = 192,
    parameter int unsigned IO_BASE     = 'hF0,
    parameter int unsigned N_OUT       = 2,
    parameter int unsigned N_IN        = 2,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ack,
    output logic                    err,
    input  logic [N_IN*DATA_W-1:0]  in_port,
    output logic [N_OUT*DATA_W-1:0] out_port,
    output logic [N_OUT-1:0]        out_strobe
);

    // RAM index width; a one-word RAM still needs a one-bit index.
    localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       commit;

    // Transfer captured at the accept edge.
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    // Registered outputs.
    logic                    ack_q;
    logic                    err_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [N_OUT*DATA_W-1:0] out_q;
    logic [N_OUT-1:0]        strobe_q;

    // Two-flop synchroniser on the asynchronous input channels.
    logic [N_IN*DATA_W-1:0] sync1_q;
    logic [N_IN*DATA_W-1:0] sync2_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Decode of the latched address.
    logic [31:0]       addr_ext;
    logic              is_mem;
    logic [N_OUT-1:0]  out_hit;
    logic [N_IN-1:0]   in_hit;
    logic              unmapped;
    logic [MemAw-1:0]  mem_idx;
    logic [DATA_W-1:0] rd_val;

    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign out_port   = out_q;
    assign out_strobe = strobe_q;

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept from idle, count down the wait states, then one commit cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // The edge leaving this state commits the transfer and raises ack.
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Capture the transfer so the requester may change addr/we/wdata after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
        end
    end

    // Address decode and read-data mux; windows are disjoint since MEM_DEPTH <= IO_BASE.
    always_comb begin
        addr_ext = 32'(addr_q);
        is_mem   = addr_ext < MEM_DEPTH;
        out_hit  = '0;
        in_hit   = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            out_hit[k] = addr_ext == IO_BASE + k;
        end
        for (int unsigned k = 0; k < N_IN; k++) begin
            in_hit[k] = addr_ext == IO_BASE + N_OUT + k;
        end
        unmapped = ~(is_mem | (|out_hit) | (|in_hit));
        mem_idx  = addr_q[MemAw-1:0];
        rd_val   = '0;
        if (is_mem) begin
            rd_val = mem[mem_idx];
        end
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (out_hit[k]) begin
                rd_val = out_q[k*DATA_W +: DATA_W];
            end
        end
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (in_hit[k]) begin
                rd_val = sync2_q[k*DATA_W +: DATA_W];
            end
        end
    end

    // RAM write on the commit edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit && we_q && is_mem) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    // Response and output-channel registers, all updated on the commit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            out_q    <= '0;
            strobe_q <= '0;
        end else begin
            ack_q    <= commit;
            err_q    <= commit & unmapped;
            strobe_q <= (commit && we_q) ? out_hit : '0;
            if (commit && we_q) begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (out_hit[k]) begin
                        out_q[k*DATA_W +: DATA_W] <= wdata_q;
                    end
                end
            end
            // Writes leave rdata holding the last read result.
            if (commit && !we_q) begin
                rdata_q <= rd_val;
            end
        end
    end

    // Input synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

endmodule

// File: tb/tb_mcu_mem_bus.sv
// Bench for mcu_mem_bus: three instances (1, 0 and 3 wait states) share one stimulus
// stream and are compared every cycle against a transaction-level model, plus
// hand-computed checks on the default instance.
module tb_mcu_mem_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  wdata = 8'h00;
    logic [15:0] in_port = 16'h0000;

    logic [7:0]  rdata_w [3];
    logic        ack_w [3];
    logic        err_w [3];
    logic [15:0] out_w [3];
    logic [1:0]  strobe_w [3];

    int checks = 0;
    int failures = 0;

    // Model state, one slot per instance.
    int     ws [3] = '{1, 0, 3};
    bit     busy [3];
    longint commit_at [3];
    bit     t_we [3];
    int     t_addr [3];
    int     t_wdata [3];
    bit     e_ack [3];
    bit     e_err [3];
    int     e_rdata [3];
    bit     e_known [3];
    int     e_out [3][2];
    bit     e_strobe [3][2];
    int     mem [3][256];
    bit     mem_ok [3][256];
    int     h1;
    int     h2;
    longint cyc = 0;

    mcu_mem_bus #(.WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[0]), .ack(ack_w[0]), .err(err_w[0]), .in_port(in_port),
        .out_port(out_w[0]), .out_strobe(strobe_w[0])
    );
    mcu_mem_bus #(.WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[1]), .ack(ack_w[1]), .err(err_w[1]), .in_port(in_port),
        .out_port(out_w[1]), .out_strobe(strobe_w[1])
    );
    mcu_mem_bus #(.WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_w[2]), .ack(ack_w[2]), .err(err_w[2]), .in_port(in_port),
        .out_port(out_w[2]), .out_strobe(strobe_w[2])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            busy[i]    = 1'b0;
            e_ack[i]   = 1'b0;
            e_err[i]   = 1'b0;
            e_rdata[i] = 0;
            e_known[i] = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e_out[i][k]    = 0;
                e_strobe[i][k] = 1'b0;
            end
        end
        h1 = 0;
        h2 = 0;
    endtask

    // Completion of a transfer: memory map rules applied to the captured request.
    task automatic model_commit(input int i);
        int a;
        a = t_addr[i];
        e_ack[i] = 1'b1;
        if (a < 192) begin
            if (t_we[i]) begin
                mem[i][a]    = t_wdata[i];
                mem_ok[i][a] = 1'b1;
            end else begin
                e_rdata[i] = mem[i][a];
                e_known[i] = mem_ok[i][a];
            end
        end else if (a >= 'hF0 && a < 'hF2) begin
            if (t_we[i]) begin
                e_out[i][a - 'hF0]    = t_wdata[i];
                e_strobe[i][a - 'hF0] = 1'b1;
            end else begin
                e_rdata[i] = e_out[i][a - 'hF0];
                e_known[i] = 1'b1;
            end
        end else if (a >= 'hF2 && a < 'hF4) begin
            // Input seen at a commit edge is what in_port held two edges earlier.
            if (!t_we[i]) begin
                e_rdata[i] = (h2 >> (8 * (a - 'hF2))) & 'hFF;
                e_known[i] = 1'b1;
            end
        end else begin
            e_err[i] = 1'b1;
            if (!t_we[i]) begin
                e_rdata[i] = 0;
                e_known[i] = 1'b1;
            end
        end
        busy[i] = 1'b0;
    endtask

    // Reference model: accept when not busy, complete ws+1 edges later.
    initial begin
        bit was;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                cyc++;
                for (int i = 0; i < 3; i++) begin
                    was            = busy[i];
                    e_ack[i]       = 1'b0;
                    e_err[i]       = 1'b0;
                    e_strobe[i][0] = 1'b0;
                    e_strobe[i][1] = 1'b0;
                    if (was && cyc == commit_at[i]) begin
                        model_commit(i);
                    end
                    if (!was && req) begin
                        busy[i]      = 1'b1;
                        commit_at[i] = cyc + longint'(ws[i]) + 1;
                        t_we[i]      = we;
                        t_addr[i]    = int'(addr);
                        t_wdata[i]   = int'(wdata);
                    end
                end
                h2 = h1;
                h1 = int'(in_port);
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ack[%0d]", i), int'(ack_w[i]), int'(e_ack[i]));
            chk($sformatf("err[%0d]", i), int'(err_w[i]), int'(e_err[i]));
            chk($sformatf("out_port[%0d]", i), int'(out_w[i]),
                (e_out[i][1] << 8) | e_out[i][0]);
            chk($sformatf("out_strobe[%0d]", i), int'(strobe_w[i]),
                (int'(e_strobe[i][1]) << 1) | int'(e_strobe[i][0]));
            if (e_known[i]) begin
                chk($sformatf("rdata[%0d]", i), int'(rdata_w[i]), e_rdata[i]);
            end
        end
    end

    // One transfer on the 1-wait-state instance; returns at the negedge of its ack cycle.
    task automatic xfer(input bit w, input int a, input int d, output int rd, output int e,
                        output int lat, output int op, output int st);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = 8'(a);
        wdata = 8'(d);
        @(posedge clk);
        #1;
        // Scramble the request lines: the controller must have captured them already.
        req   = 1'b0;
        we    = 1'($urandom);
        addr  = 8'($urandom);
        wdata = 8'($urandom);
        lat   = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ack_w[0] && lat < 40);
        chk("ack_seen", int'(ack_w[0]), 1);
        rd = int'(rdata_w[0]);
        e  = int'(err_w[0]);
        op = int'(out_w[0]);
        st = int'(strobe_w[0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_ack"}, int'(ack_w[i]), 0);
            chk({tag, "_err"}, int'(err_w[i]), 0);
            chk({tag, "_rdata"}, int'(rdata_w[i]), 0);
            chk({tag, "_out"}, int'(out_w[i]), 0);
            chk({tag, "_strobe"}, int'(strobe_w[i]), 0);
        end
    endtask

    initial begin
        int rd, e, lat, op, st;
        int last [3];
        int exp_iv [3] = '{3, 2, 5};
        int r;

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Aborted write: a reset in WAIT must leave the RAM word untouched.
        xfer(1'b1, 'h10, 'h11, rd, e, lat, op, st);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 8'h5A;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        xfer(1'b0, 'h10, 0, rd, e, lat, op, st);
        chk("abort_rdata", rd, 'h11);
        chk("abort_err", e, 0);

        // RAM write then read, both with two-cycle latency.
        xfer(1'b1, 'h05, 'h3C, rd, e, lat, op, st);
        chk("wr_lat", lat, 2);
        chk("wr_err", e, 0);
        xfer(1'b0, 'h05, 0, rd, e, lat, op, st);
        chk("rd_lat", lat, 2);
        chk("rd_data", rd, 'h3C);

        // Output channel 1.
        xfer(1'b1, 'hF1, 'hA5, rd, e, lat, op, st);
        chk("out_port_val", op, 'hA500);
        chk("out_strobe_val", st, 'b10);
        @(negedge clk);
        chk("out_strobe_clear", int'(strobe_w[0]), 0);
        xfer(1'b0, 'hF1, 0, rd, e, lat, op, st);
        chk("out_readback", rd, 'hA5);

        // Input channel 1 after synchronisation; writes to it are ignored.
        @(negedge clk);
        in_port = 16'h7E00;
        repeat (3) @(negedge clk);
        xfer(1'b0, 'hF3, 0, rd, e, lat, op, st);
        chk("in_read", rd, 'h7E);
        xfer(1'b1, 'hF3, 'h11, rd, e, lat, op, st);
        chk("in_write_err", e, 0);
        chk("in_write_out", op, 'hA500);
        chk("in_write_rdata", rd, 'h7E);

        // Unmapped read and write.
        xfer(1'b0, 'hC0, 0, rd, e, lat, op, st);
        chk("unmapped_rd_err", e, 1);
        chk("unmapped_rd_data", rd, 0);
        xfer(1'b1, 'hFF, 'h77, rd, e, lat, op, st);
        chk("unmapped_wr_err", e, 1);
        chk("unmapped_wr_data", rd, 0);
        chk("unmapped_wr_out", op, 'hA500);
        xfer(1'b0, 'h05, 0, rd, e, lat, op, st);
        chk("ram_intact", rd, 'h3C);

        // Back-to-back: req held high, ack spacing is ws+2 for each instance.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h05;
        for (int i = 0; i < 3; i++) last[i] = -1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ack_w[i]) begin
                    if (last[i] >= 0) begin
                        chk($sformatf("ack_interval[%0d]", i), n - last[i], exp_iv[i]);
                    end
                    last[i] = n;
                end
            end
        end
        req = 1'b0;
        repeat (8) @(negedge clk);

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            wdata = 8'($urandom);
            r     = int'($urandom_range(0, 7));
            if (r < 5) addr = 8'($urandom_range(0, 15));
            else if (r == 5) addr = 8'($urandom_range('hF0, 'hF3));
            else if (r == 6) addr = 8'($urandom_range('hC0, 'hFF));
            else addr = 8'($urandom);
            if ($urandom_range(0, 7) == 0) in_port = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #3 rst = 1'b0;
                #1 check_reset_outputs("rand_reset");
                @(negedge clk);
                rst = 1'b1;
            end
        end
        req = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
